// File: rtl/spi_mon_pkg.sv
// Shared types and frame-length helpers for the SPI frame monitor.
package spi_mon_pkg;

  typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, TURN, RESP, OVERRUN} state_e;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  function automatic int unsigned len_wr(input int unsigned cmd_w, input int unsigned data_w);
    return cmd_w + data_w;
  endfunction

  // Read-data frames add one turnaround cycle plus the response bits.
  function automatic int unsigned len_rd(input int unsigned cmd_w, input int unsigned data_w);
    return cmd_w + data_w + 1 + data_w;
  endfunction

endpackage

// File: rtl/spi_mon_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module spi_mon_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/spi_frame_monitor.sv
// Passive SPI frame monitor: decodes SS_n-bounded frames, checks length and MISO
// discipline, and keeps saturating frame/error counters. Never drives the bus.
module spi_frame_monitor
  import spi_mon_pkg::*;
#(
  parameter int unsigned CMD_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ss_n,
  input  logic                  i_mosi,
  input  logic                  i_miso,
  input  logic                  i_clr_cnt,
  output logic                  o_frame_valid,
  output logic [CMD_WIDTH-1:0]  o_frame_cmd,
  output logic [DATA_WIDTH-1:0] o_frame_data,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_err_len,
  output logic                  o_err_miso,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_err_cnt
);

  localparam int unsigned LenWr   = len_wr(CMD_WIDTH, DATA_WIDTH);
  localparam int unsigned LenRd   = len_rd(CMD_WIDTH, DATA_WIDTH);
  localparam int unsigned LenBits = $clog2(LenRd + 1);

  localparam logic [LenBits-1:0] LenW       = LenBits'(LenWr);
  localparam logic [LenBits-1:0] LenR       = LenBits'(LenRd);
  localparam logic [LenBits-1:0] LenCmdLast = LenBits'(CMD_WIDTH - 1);
  localparam logic [LenBits-1:0] LenWLast   = LenBits'(LenWr - 1);
  localparam logic [LenBits-1:0] LenRLast   = LenBits'(LenRd - 1);

  state_e                r_state, w_state_nxt;
  logic [LenBits-1:0]    r_len, w_len_nxt;
  logic [CMD_WIDTH-1:0]  r_cmd, w_cmd_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [DATA_WIDTH-1:0] r_resp, w_resp_nxt;
  logic                  r_too_long, w_too_long_nxt;
  logic                  r_miso_seen, w_miso_seen_nxt;
  logic                  w_valid, w_err_len, w_err_miso;
  logic                  w_is_rd;
  logic [LenBits-1:0]    w_exp_len;

  logic                  r_frame_valid, r_err_len, r_err_miso;
  logic [CMD_WIDTH-1:0]  r_frame_cmd;
  logic [DATA_WIDTH-1:0] r_frame_data, r_resp_data;

  assign w_is_rd   = (r_cmd == CMD_WIDTH'(RD_DATA));
  assign w_exp_len = w_is_rd ? LenR : LenW;

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_cmd_nxt       = r_cmd;
    w_data_nxt      = r_data;
    w_resp_nxt      = r_resp;
    w_too_long_nxt  = r_too_long;
    w_miso_seen_nxt = r_miso_seen;
    w_valid         = 1'b0;
    w_err_len       = 1'b0;
    w_err_miso      = 1'b0;

    if (r_state == IDLE) begin
      if (!i_ss_n) begin
        // Start cycle: no bit sampled, but MISO must already be quiet.
        w_state_nxt     = CMD;
        w_len_nxt       = '0;
        w_cmd_nxt       = '0;
        w_data_nxt      = '0;
        w_resp_nxt      = '0;
        w_too_long_nxt  = 1'b0;
        w_miso_seen_nxt = i_miso;
        w_err_miso      = i_miso;
      end
    end else if (i_ss_n) begin
      w_state_nxt     = IDLE;
      w_too_long_nxt  = 1'b0;
      w_miso_seen_nxt = 1'b0;
      if (!r_too_long && (r_len == w_exp_len)) begin
        w_valid = 1'b1;
      end else begin
        w_err_len = 1'b1;
      end
    end else begin
      if ((r_state != RESP) && i_miso && !r_miso_seen) begin
        w_err_miso      = 1'b1;
        w_miso_seen_nxt = 1'b1;
      end
      case (r_state)
        CMD: begin
          w_cmd_nxt = (r_cmd << 1) | CMD_WIDTH'(i_mosi);
          w_len_nxt = r_len + LenBits'(1);
          if (r_len == LenCmdLast) w_state_nxt = PAYLOAD;
        end
        PAYLOAD: begin
          w_data_nxt = {r_data[DATA_WIDTH-2:0], i_mosi};
          w_len_nxt  = r_len + LenBits'(1);
          if (r_len == LenWLast) w_state_nxt = w_is_rd ? TURN : OVERRUN;
        end
        TURN: begin
          w_len_nxt   = r_len + LenBits'(1);
          w_state_nxt = RESP;
        end
        RESP: begin
          w_resp_nxt = {r_resp[DATA_WIDTH-2:0], i_miso};
          w_len_nxt  = r_len + LenBits'(1);
          if (r_len == LenRLast) w_state_nxt = OVERRUN;
        end
        OVERRUN: w_too_long_nxt = 1'b1;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_cmd         <= '0;
      r_data        <= '0;
      r_resp        <= '0;
      r_too_long    <= 1'b0;
      r_miso_seen   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_miso    <= 1'b0;
      r_frame_cmd   <= '0;
      r_frame_data  <= '0;
      r_resp_data   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_len         <= w_len_nxt;
      r_cmd         <= w_cmd_nxt;
      r_data        <= w_data_nxt;
      r_resp        <= w_resp_nxt;
      r_too_long    <= w_too_long_nxt;
      r_miso_seen   <= w_miso_seen_nxt;
      r_frame_valid <= w_valid;
      r_err_len     <= w_err_len;
      r_err_miso    <= w_err_miso;
      if (w_valid) begin
        r_frame_cmd  <= r_cmd;
        r_frame_data <= r_data;
        if (w_is_rd) r_resp_data <= r_resp;
      end
    end
  end

  // Counters track the registered pulses, so a clear in the pulse cycle wins.
  spi_mon_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_frame_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (r_frame_valid),
    .i_clr   (i_clr_cnt),
    .o_cnt   (o_frame_cnt)
  );

  spi_mon_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (r_err_len | r_err_miso),
    .i_clr   (i_clr_cnt),
    .o_cnt   (o_err_cnt)
  );

  assign o_frame_valid = r_frame_valid;
  assign o_err_len     = r_err_len;
  assign o_err_miso    = r_err_miso;
  assign o_frame_cmd   = r_frame_cmd;
  assign o_frame_data  = r_frame_data;
  assign o_resp_data   = r_resp_data;

endmodule

// File: tb/tb_spi_frame_monitor.sv
// Directed table-driven bench for spi_frame_monitor, with a 2-bit-counter
// instance alongside to exercise saturation.
module tb_spi_frame_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ss_n, mosi, miso, clr_cnt;

  logic       fv, el, em;
  logic [1:0] fcmd;
  logic [7:0] fdata, rdata;
  logic [15:0] fcnt, ecnt;

  logic       s_fv, s_el, s_em;
  logic [1:0] s_fcmd;
  logic [7:0] s_fdata, s_rdata;
  logic [1:0] s_fcnt, s_ecnt;

  spi_frame_monitor dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ss_n        (ss_n),
    .i_mosi        (mosi),
    .i_miso        (miso),
    .i_clr_cnt     (clr_cnt),
    .o_frame_valid (fv),
    .o_frame_cmd   (fcmd),
    .o_frame_data  (fdata),
    .o_resp_data   (rdata),
    .o_err_len     (el),
    .o_err_miso    (em),
    .o_frame_cnt   (fcnt),
    .o_err_cnt     (ecnt)
  );

  spi_frame_monitor #(
    .CNT_WIDTH (2)
  ) dut_sat (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ss_n        (ss_n),
    .i_mosi        (mosi),
    .i_miso        (miso),
    .i_clr_cnt     (clr_cnt),
    .o_frame_valid (s_fv),
    .o_frame_cmd   (s_fcmd),
    .o_frame_data  (s_fdata),
    .o_resp_data   (s_rdata),
    .o_err_len     (s_el),
    .o_err_miso    (s_em),
    .o_frame_cnt   (s_fcnt),
    .o_err_cnt     (s_ecnt)
  );

  typedef struct {
    int          nbits;
    logic [31:0] mosi;
    logic [31:0] miso;
    logic        clr;
    int          n_valid;
    int          n_len;
    int          n_miso;
    logic [1:0]  cmd;
    logic [7:0]  data;
    logic [7:0]  resp;
    int          fcnt;
    int          ecnt;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int acc_v, acc_l, acc_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    acc_v += int'(fv);
    acc_l += int'(el);
    acc_m += int'(em);
  endtask

  // Start cycle, nbits sampled cycles (MSB first), end cycle, then one settle cycle.
  task automatic run_vec(input string tag, input vec_t v);
    acc_v = 0;
    acc_l = 0;
    acc_m = 0;
    ss_n = 1'b0;
    mosi = 1'b0;
    miso = 1'b0;
    tick();
    for (int k = 1; k <= v.nbits; k++) begin
      mosi = v.mosi[v.nbits-k];
      miso = v.miso[v.nbits-k];
      tick();
    end
    ss_n = 1'b1;
    mosi = 1'b0;
    miso = 1'b0;
    tick();
    clr_cnt = v.clr;
    tick();
    clr_cnt = 1'b0;
    check({tag, "_valid"}, 32'(acc_v), 32'(v.n_valid));
    check({tag, "_errlen"}, 32'(acc_l), 32'(v.n_len));
    check({tag, "_errmiso"}, 32'(acc_m), 32'(v.n_miso));
    check({tag, "_cmd"}, 32'(fcmd), 32'(v.cmd));
    check({tag, "_data"}, 32'(fdata), 32'(v.data));
    check({tag, "_resp"}, 32'(rdata), 32'(v.resp));
    check({tag, "_fcnt"}, 32'(fcnt), 32'(v.fcnt));
    check({tag, "_ecnt"}, 32'(ecnt), 32'(v.ecnt));
  endtask

  vec_t vecs[9];
  vec_t post_rst;

  initial begin
    //               n   mosi      miso      clr  v  l  m  cmd  data   resp   fc ec
    vecs[0] = '{10, 32'h0A5,   32'h000, 1'b0, 1, 0, 0, 2'd0, 8'hA5, 8'h00, 1, 0};
    vecs[1] = '{19, 32'h67800, 32'h096, 1'b0, 1, 0, 0, 2'd3, 8'h3C, 8'h96, 2, 0};
    vecs[2] = '{7,  32'h05F,   32'h000, 1'b0, 0, 1, 0, 2'd3, 8'h3C, 8'h96, 2, 1};
    vecs[3] = '{12, 32'h444,   32'h000, 1'b0, 0, 1, 0, 2'd3, 8'h3C, 8'h96, 2, 2};
    vecs[4] = '{10, 32'h15A,   32'h030, 1'b0, 1, 0, 1, 2'd1, 8'h5A, 8'h96, 3, 3};
    vecs[5] = '{10, 32'h2C3,   32'h000, 1'b0, 1, 0, 0, 2'd2, 8'hC3, 8'h96, 4, 3};
    vecs[6] = '{10, 32'h3FF,   32'h000, 1'b0, 0, 1, 0, 2'd2, 8'hC3, 8'h96, 4, 4};
    vecs[7] = '{19, 32'h60200, 32'h15A, 1'b0, 1, 0, 1, 2'd3, 8'h01, 8'h5A, 5, 5};
    vecs[8] = '{10, 32'h077,   32'h000, 1'b1, 1, 0, 0, 2'd0, 8'h77, 8'h5A, 0, 0};
    post_rst = '{10, 32'h03C,  32'h000, 1'b0, 1, 0, 0, 2'd0, 8'h3C, 8'h00, 1, 0};

    rst_n = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    miso = 1'b0;
    clr_cnt = 1'b0;
    acc_v = 0;
    acc_l = 0;
    acc_m = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(fv), 32'd0);
    check("rst_errs", 32'({el, em}), 32'd0);
    check("rst_cmd_data", 32'({fcmd, fdata, rdata}), 32'd0);
    check("rst_cnts", 32'({fcnt, ecnt}), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
      if (i == 7) begin
        check("sat_fcnt", 32'(s_fcnt), 32'd3);
        check("sat_ecnt", 32'(s_ecnt), 32'd3);
      end
    end
    check("sat_fcnt_clr", 32'(s_fcnt), 32'd0);

    // Reset in the middle of a write frame's payload.
    ss_n = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      mosi = k[0];
      tick();
    end
    rst_n = 1'b0;
    ss_n = 1'b1;
    #1;
    check("midrst_data", 32'({fcmd, fdata}), 32'd0);
    check("midrst_resp", 32'(rdata), 32'd0);
    check("midrst_pulses", 32'({fv, el, em}), 32'd0);
    acc_v = 0;
    acc_l = 0;
    acc_m = 0;
    tick();
    tick();
    check("midrst_quiet", 32'(acc_v + acc_l + acc_m), 32'd0);
    rst_n = 1'b1;
    tick();
    run_vec("post_rst", post_rst);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
